// File: rtl/fighter_pkg.sv
// Shared definitions for the fighter action sequencer: decoder state codes,
// internal FSM encoding (adds STUN) and the mapping between them.
package fighter_pkg;

    typedef logic [1:0] pstate_t;

    localparam logic [1:0] PS_IDLE   = 2'b00;
    localparam logic [1:0] PS_MOVE   = 2'b01;
    localparam logic [1:0] PS_DEFEND = 2'b10;
    localparam logic [1:0] PS_ATTACK = 2'b11;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_MOVE   = 3'd1;
    localparam logic [2:0] ST_DEFEND = 3'd2;
    localparam logic [2:0] ST_ATTACK = 3'd3;
    localparam logic [2:0] ST_STUN   = 3'd4;

    // STUN has no action line of its own, so the decoder sees it as IDLE.
    function automatic pstate_t state_code(input logic [2:0] st);
        pstate_t code;
        case (st)
            ST_MOVE:   code = PS_MOVE;
            ST_DEFEND: code = PS_DEFEND;
            ST_ATTACK: code = PS_ATTACK;
            default:   code = PS_IDLE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/fighter_action_ctrl_tick_down_counter.sv
// Down-counter advanced only on game ticks: load wins over decrement, and the
// count saturates at zero. next_zero predicts the zero flag after this cycle.
module tick_down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tick,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         zero,
    output logic         next_zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (tick) begin
            if (load) begin
                count <= load_val;
            end else if (count != '0) begin
                count <= count - 1'b1;
            end
        end
    end

    assign zero = (count == '0);

    always_comb begin
        next_zero = zero;
        if (tick) begin
            if (load) begin
                next_zero = (load_val == '0);
            end else begin
                next_zero = (count == '0) || (count == W'(1));
            end
        end
    end

endmodule

// File: rtl/fighter_action_ctrl.sv
// Per-player action sequencer: arbitrates move/attack/defend, times attacks,
// defends, hit-stun and (with ATTACK_COOLDOWN_EN defined) attack cooldown.
//
// state  | meaning
// IDLE   | no action, requests arbitrated
// MOVE   | moving, re-arbitrated every tick
// DEFEND | blocking; held at least DEFEND_MIN_TICKS, then while defendReq
// ATTACK | attack in progress for ATTACK_TICKS, not abortable by buttons
// STUN   | hit-stun after an unblocked hit, requests ignored
module fighter_action_ctrl
    import fighter_pkg::*;
#(
    parameter int ATTACK_TICKS     = 8,
    parameter int DEFEND_MIN_TICKS = 4,
    parameter int STUN_TICKS       = 12,
    parameter int COOLDOWN_TICKS   = 16,
    parameter int CNT_W            = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       moveReq,
    input  logic       attackReq,
    input  logic       defendReq,
    input  logic       hitIn,
    output logic [1:0] playerState,
    output logic       busy,
    output logic       attackStrobe,
    output logic       blockStrobe
);

    localparam logic [CNT_W-1:0] ATTACK_LOAD = CNT_W'(ATTACK_TICKS - 1);
    localparam logic [CNT_W-1:0] DEFEND_LOAD = CNT_W'(DEFEND_MIN_TICKS - 1);
    localparam logic [CNT_W-1:0] STUN_LOAD   = CNT_W'(STUN_TICKS - 1);

    if (ATTACK_TICKS < 1 || DEFEND_MIN_TICKS < 1 || STUN_TICKS < 1 ||
        COOLDOWN_TICKS < 0 ||
        ATTACK_TICKS >= 2**CNT_W || DEFEND_MIN_TICKS >= 2**CNT_W ||
        STUN_TICKS >= 2**CNT_W || COOLDOWN_TICKS >= 2**CNT_W) begin : g_bad_params
        $error("fighter_action_ctrl: tick parameter out of range for CNT_W");
    end

    logic [2:0]       state;
    logic [2:0]       state_nx;
    logic             hit_pend;
    logic             hit;
    logic             act_load;
    logic [CNT_W-1:0] act_val;
    logic [CNT_W-1:0] act_count;
    logic             act_zero;
    logic             act_next_zero;
    logic             cd_zero;
    logic             astb_nx;
    logic             bstb_nx;
    logic             busy_nx;

    // A hit arriving on the tick cycle itself is handled by that tick.
    assign hit = hit_pend | hitIn;

    tick_down_counter #(.W(CNT_W)) u_act_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .load      (act_load),
        .load_val  (act_val),
        .count     (act_count),
        .zero      (act_zero),
        .next_zero (act_next_zero)
    );

`ifdef ATTACK_COOLDOWN_EN
    logic             cd_load;
    logic [CNT_W-1:0] cd_count;
    logic             cd_next_zero;

    // Cooldown starts whenever ATTACK is left, whether it ran out or was hit.
    assign cd_load = (state == ST_ATTACK) && (hit || act_zero);

    tick_down_counter #(.W(CNT_W)) u_cd_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .load      (cd_load),
        .load_val  (CNT_W'(COOLDOWN_TICKS)),
        .count     (cd_count),
        .zero      (cd_zero),
        .next_zero (cd_next_zero)
    );
`else
    assign cd_zero = 1'b1;
`endif

    always_comb begin
        state_nx = state;
        act_load = 1'b0;
        act_val  = '0;
        astb_nx  = 1'b0;
        bstb_nx  = 1'b0;
        if (hit) begin
            if (state == ST_DEFEND) begin
                bstb_nx = 1'b1;
            end else begin
                state_nx = ST_STUN;
                act_load = 1'b1;
                act_val  = STUN_LOAD;
            end
        end else begin
            case (state)
                ST_IDLE, ST_MOVE: begin
                    if (attackReq && cd_zero) begin
                        state_nx = ST_ATTACK;
                        act_load = 1'b1;
                        act_val  = ATTACK_LOAD;
                        astb_nx  = 1'b1;
                    end else if (defendReq) begin
                        state_nx = ST_DEFEND;
                        act_load = 1'b1;
                        act_val  = DEFEND_LOAD;
                    end else if (moveReq) begin
                        state_nx = ST_MOVE;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
                ST_ATTACK: begin
                    if (act_zero) state_nx = ST_IDLE;
                end
                ST_DEFEND: begin
                    if (act_zero && !defendReq) state_nx = ST_IDLE;
                end
                ST_STUN: begin
                    if (act_zero) state_nx = ST_IDLE;
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    assign busy_nx = (state_nx == ST_ATTACK) || (state_nx == ST_STUN) ||
                     ((state_nx == ST_DEFEND) && !act_next_zero);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            hit_pend     <= 1'b0;
            playerState  <= PS_IDLE;
            busy         <= 1'b0;
            attackStrobe <= 1'b0;
            blockStrobe  <= 1'b0;
        end else if (tick) begin
            state        <= state_nx;
            hit_pend     <= 1'b0;
            playerState  <= state_code(state_nx);
            busy         <= busy_nx;
            attackStrobe <= astb_nx;
            blockStrobe  <= bstb_nx;
        end else begin
            hit_pend     <= hit_pend | hitIn;
            attackStrobe <= 1'b0;
            blockStrobe  <= 1'b0;
        end
    end

endmodule
